// File: rtl/vdu_pkg.sv
// vdu_pkg: shared constants for the VDU video-RAM arbiter.
//   - default address/data widths of the 2048x16 video RAM
//   - CPU-side FSM state encoding (IDLE, BUSY, ACK, TACK)
//   - RAM byte-enable constants ([1]=attribute byte, [0]=char byte)
package vdu_pkg;

   localparam int VDU_AW          = 11;
   localparam int VDU_DW          = 16;
   localparam int VDU_STALL_LIMIT = 16;
   localparam int VDU_CW          = 8;

   // CPU access FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for a CPU strobe
   localparam logic [1:0] ST_BUSY = 2'd1;  // RAM op for the CPU is on the port
   localparam logic [1:0] ST_ACK  = 2'd2;  // RAM access acknowledged
   localparam logic [1:0] ST_TACK = 2'd3;  // register-space access acknowledged

   localparam logic [1:0] BE_NONE = 2'b00;
   localparam logic [1:0] BE_BOTH = 2'b11;

endpackage

// File: rtl/vdu_stall_mon.sv
// vdu_stall_mon: CPU starvation monitor.
//   clk_i       in   clock
//   rst_ni      in   asynchronous active-low reset
//   inc_i       in   CPU wanted the RAM this edge but display took it
//   clr_i       in   CPU granted, or no CPU access pending
//   cnt_o       out  consecutive denied cycles, saturating at 2**CW-1
//   overrun_o   out  sticky flag, set once cnt_o reaches STALL_LIMIT
module vdu_stall_mon #(
   parameter int CW          = 8,
   parameter int STALL_LIMIT = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          inc_i,
   input  logic          clr_i,
   output logic [CW-1:0] cnt_o,
   output logic          overrun_o
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          overrun_q, overrun_d;

   always_comb begin
      cnt_d     = cnt_q;
      overrun_d = overrun_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CW{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
      // Compared at integer width so an unreachable limit never matches
      // through truncation; a zero limit is treated as "never".
      if ((STALL_LIMIT != 0) && (int'(cnt_d) == STALL_LIMIT)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/vdu_mem_arbiter.sv
// vdu_mem_arbiter: arbitrates the single-port video RAM between the CPU
// Wishbone slave and the real-time display fetch pipeline.
//   wb_clk_i/wb_rst_ni     clock, asynchronous active-low reset
//   wb_*                   Wishbone slave (classic single access)
//   disp_req_i/disp_adr_i  display fetch request, one per cycle allowed
//   disp_dat_o/disp_vld_o  fetched word, two cycles after the request edge
//   ram_*_o                registered RAM port; ram_dat_i is synchronous
//   stall_cnt_o            denied cycles of the current CPU access
//   overrun_o              sticky CPU starvation flag
//
// Handshakes: a CPU access is a request while wb_cyc_i & wb_stb_i are high
// and completes on the single cycle wb_ack_o=1; the master must drop or
// change stb after that cycle. Display requests are never refused:
// every edge that samples disp_req_i=1 yields exactly one disp_vld_o=1
// cycle, two cycles later, in request order.
module vdu_mem_arbiter
   import vdu_pkg::*;
#(
   parameter int AW          = VDU_AW,
   parameter int DW          = VDU_DW,
   parameter int STALL_LIMIT = VDU_STALL_LIMIT,
   parameter int CW          = VDU_CW
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic [DW-1:0] wb_dat_i,
   output logic [DW-1:0] wb_dat_o,
   input  logic [AW-1:0] wb_adr_i,
   input  logic          wb_we_i,
   input  logic          wb_tga_i,
   input  logic [1:0]    wb_sel_i,
   input  logic          wb_stb_i,
   input  logic          wb_cyc_i,
   output logic          wb_ack_o,
   input  logic          disp_req_i,
   input  logic [AW-1:0] disp_adr_i,
   output logic [DW-1:0] disp_dat_o,
   output logic          disp_vld_o,
   output logic [AW-1:0] ram_adr_o,
   output logic          ram_we_o,
   output logic [1:0]    ram_be_o,
   output logic [DW-1:0] ram_dat_o,
   input  logic [DW-1:0] ram_dat_i,
   output logic [CW-1:0] stall_cnt_o,
   output logic          overrun_o
);

   logic [1:0]    state_q, state_d;
   logic          cpu_we_q, cpu_we_d;
   logic          disp_p1_q, disp_p1_d;
   logic          disp_vld_q, disp_vld_d;
   logic [AW-1:0] ram_adr_q, ram_adr_d;
   logic          ram_we_q, ram_we_d;
   logic [1:0]    ram_be_q, ram_be_d;
   logic [DW-1:0] ram_dat_q, ram_dat_d;

   logic cpu_pend;
   logic cpu_gnt;
   logic stall_inc;
   logic stall_clr;

   // Only IDLE accepts a strobe, so the edge leaving ACK/TACK cannot
   // re-grant a strobe the master is still holding.
   assign cpu_pend  = wb_cyc_i & wb_stb_i & (state_q == ST_IDLE);
   assign cpu_gnt   = ~disp_req_i & cpu_pend & ~wb_tga_i;
   assign stall_inc = cpu_pend & ~wb_tga_i & disp_req_i;
   assign stall_clr = cpu_gnt | ~cpu_pend;

   always_comb begin
      state_d    = state_q;
      cpu_we_d   = cpu_we_q;
      disp_p1_d  = disp_req_i;
      disp_vld_d = disp_p1_q;
      ram_adr_d  = ram_adr_q;
      ram_we_d   = 1'b0;
      ram_be_d   = ram_be_q;
      ram_dat_d  = ram_dat_q;

      if (disp_req_i) begin
         ram_adr_d = disp_adr_i;
         ram_be_d  = BE_BOTH;
      end else if (cpu_gnt) begin
         ram_adr_d = wb_adr_i;
         ram_we_d  = wb_we_i;
         ram_be_d  = wb_sel_i;
         ram_dat_d = wb_dat_i;
         cpu_we_d  = wb_we_i;
      end

      case (state_q)
         ST_IDLE: begin
            if (cpu_pend && wb_tga_i) begin
               state_d = ST_TACK;
            end else if (cpu_gnt) begin
               state_d = ST_BUSY;
            end
         end
         // The RAM op is already on the port; it completes and is acked
         // even if the master drops cyc meanwhile.
         ST_BUSY: state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         ST_TACK: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= ST_IDLE;
         cpu_we_q   <= 1'b0;
         disp_p1_q  <= 1'b0;
         disp_vld_q <= 1'b0;
         ram_adr_q  <= '0;
         ram_we_q   <= 1'b0;
         ram_be_q   <= BE_NONE;
         ram_dat_q  <= '0;
      end else begin
         state_q    <= state_d;
         cpu_we_q   <= cpu_we_d;
         disp_p1_q  <= disp_p1_d;
         disp_vld_q <= disp_vld_d;
         ram_adr_q  <= ram_adr_d;
         ram_we_q   <= ram_we_d;
         ram_be_q   <= ram_be_d;
         ram_dat_q  <= ram_dat_d;
      end
   end

   vdu_stall_mon #(
      .CW          (CW),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall_mon (
      .clk_i     (wb_clk_i),
      .rst_ni    (wb_rst_ni),
      .inc_i     (stall_inc),
      .clr_i     (stall_clr),
      .cnt_o     (stall_cnt_o),
      .overrun_o (overrun_o)
   );

   // Read data arrives straight from the synchronous RAM in the cycle the
   // ack/valid is shown; gating keeps the outputs at 0 otherwise.
   assign wb_ack_o   = (state_q == ST_ACK) | (state_q == ST_TACK);
   assign wb_dat_o   = ((state_q == ST_ACK) && !cpu_we_q) ? ram_dat_i : '0;
   assign disp_vld_o = disp_vld_q;
   assign disp_dat_o = disp_vld_q ? ram_dat_i : '0;
   assign ram_adr_o  = ram_adr_q;
   assign ram_we_o   = ram_we_q;
   assign ram_be_o   = ram_be_q;
   assign ram_dat_o  = ram_dat_q;

endmodule

// File: tb/tb_vdu_mem_arbiter.sv
// tb_vdu_mem_arbiter: directed bench for vdu_mem_arbiter with a behavioural
// synchronous 2048x16 byte-enabled video RAM attached to the RAM port.
module tb_vdu_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic [15:0] wb_dat_i, wb_dat_o;
   logic [10:0] wb_adr_i;
   logic        wb_we_i, wb_tga_i, wb_stb_i, wb_cyc_i, wb_ack_o;
   logic [1:0]  wb_sel_i;
   logic        disp_req_i, disp_vld_o;
   logic [10:0] disp_adr_i;
   logic [15:0] disp_dat_o;
   logic [10:0] ram_adr_o;
   logic        ram_we_o;
   logic [1:0]  ram_be_o;
   logic [15:0] ram_dat_o, ram_dat_i;
   logic [7:0]  stall_cnt_o;
   logic        overrun_o;

   int total = 0;
   int bad   = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   vdu_mem_arbiter dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .wb_dat_i    (wb_dat_i),
      .wb_dat_o    (wb_dat_o),
      .wb_adr_i    (wb_adr_i),
      .wb_we_i     (wb_we_i),
      .wb_tga_i    (wb_tga_i),
      .wb_sel_i    (wb_sel_i),
      .wb_stb_i    (wb_stb_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_ack_o    (wb_ack_o),
      .disp_req_i  (disp_req_i),
      .disp_adr_i  (disp_adr_i),
      .disp_dat_o  (disp_dat_o),
      .disp_vld_o  (disp_vld_o),
      .ram_adr_o   (ram_adr_o),
      .ram_we_o    (ram_we_o),
      .ram_be_o    (ram_be_o),
      .ram_dat_o   (ram_dat_o),
      .ram_dat_i   (ram_dat_i),
      .stall_cnt_o (stall_cnt_o),
      .overrun_o   (overrun_o)
   );

   // ---------------- video RAM model ----------------
   logic [15:0] mem [0:2047];
   logic [15:0] ram_rd;
   logic        pl_we;
   logic [10:0] pl_adr;
   logic [15:0] pl_dat;

   always @(posedge clk) begin
      if (pl_we) mem[pl_adr] <= pl_dat;
      if (ram_we_o) begin
         if (ram_be_o[0]) mem[ram_adr_o][7:0]  <= ram_dat_o[7:0];
         if (ram_be_o[1]) mem[ram_adr_o][15:8] <= ram_dat_o[15:8];
      end
      ram_rd <= mem[ram_adr_o];
   end
   assign ram_dat_i = ram_rd;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [79:0] all_outs();
      return 80'({wb_dat_o, wb_ack_o, disp_dat_o, disp_vld_o, ram_adr_o,
                  ram_we_o, ram_be_o, ram_dat_o, stall_cnt_o, overrun_o});
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [10:0] a, input logic [15:0] d);
      pl_we  = 1'b1;
      pl_adr = a;
      pl_dat = d;
      @(posedge clk);
      #1 pl_we = 1'b0;
   endtask

   task automatic cpu_idle();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_tga_i = 1'b0;
   endtask

   task automatic cpu_read(input string tag, input logic [10:0] a, input logic [15:0] exp);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_tga_i = 1'b0;
      wb_adr_i = a; wb_sel_i = 2'b11;
      step();
      chk({tag, " busy_ack"}, 80'(wb_ack_o), 80'(0));
      chk({tag, " ram_adr"},  80'(ram_adr_o), 80'(a));
      chk({tag, " ram_we"},   80'(ram_we_o), 80'(0));
      step();
      chk({tag, " ack"},      80'(wb_ack_o), 80'(1));
      chk({tag, " dat"},      80'(wb_dat_o), 80'(exp));
      cpu_idle();
      step();
      chk({tag, " ack_width"}, 80'(wb_ack_o), 80'(0));
      chk({tag, " adr_hold"},  80'(ram_adr_o), 80'(a));
      chk({tag, " idle_we"},   80'(ram_we_o), 80'(0));
   endtask

   task automatic cpu_write(input string tag, input logic [10:0] a, input logic [15:0] d,
                            input logic [1:0] sel);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_tga_i = 1'b0;
      wb_adr_i = a; wb_dat_i = d; wb_sel_i = sel;
      step();
      chk({tag, " ram_we"},  80'(ram_we_o), 80'(1));
      chk({tag, " ram_adr"}, 80'(ram_adr_o), 80'(a));
      chk({tag, " ram_be"},  80'(ram_be_o), 80'(sel));
      chk({tag, " ram_dat"}, 80'(ram_dat_o), 80'(d));
      step();
      chk({tag, " ack"},     80'(wb_ack_o), 80'(1));
      chk({tag, " dat0"},    80'(wb_dat_o), 80'(0));
      cpu_idle();
      step();
      chk({tag, " ack_width"}, 80'(wb_ack_o), 80'(0));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      cpu_idle();
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 2'b11;
      disp_req_i = 1'b0; disp_adr_i = '0;
      pl_we = 1'b0; pl_adr = '0; pl_dat = '0;

      preload(11'h000, 16'h0041);
      preload(11'h001, 16'h0042);
      preload(11'h002, 16'h0043);
      preload(11'h003, 16'h0044);
      preload(11'h123, 16'hBEEF);
      preload(11'h020, 16'h1234);
      preload(11'h010, 16'h0000);
      chk("reset outs", all_outs(), 80'(0));

      @(negedge clk) rst_n = 1'b1;
      step();

      // Reset in the middle of a stalled CPU access and an in-flight fetch.
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 11'h123;
      disp_req_i = 1'b1; disp_adr_i = 11'h005;
      step();
      chk("pre-rst stall", 80'(stall_cnt_o), 80'(1));
      chk("pre-rst adr",   80'(ram_adr_o), 80'(11'h005));
      rst_n = 1'b0;
      #1;
      chk("async rst outs", all_outs(), 80'(0));
      step();
      chk("in-rst outs", all_outs(), 80'(0));
      cpu_idle();
      disp_req_i = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post-rst ack", 80'(wb_ack_o), 80'(0));
         chk("post-rst vld", 80'(disp_vld_o), 80'(0));
      end

      // CPU read with display idle.
      cpu_read("rd123", 11'h123, 16'hBEEF);

      // Display stream of four back-to-back fetches.
      for (int i = 0; i < 7; i++) begin
         disp_req_i = (i < 4);
         disp_adr_i = 11'(i);
         step();
         chk("strm vld", 80'(disp_vld_o), 80'((i >= 1 && i <= 4) ? 1 : 0));
         if (i >= 1 && i <= 4)
            chk("strm dat", 80'(disp_dat_o), 80'(16'h0041 + 16'(i - 1)));
      end

      // Contention: display holds the port for 20 cycles.
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_tga_i = 1'b0;
      wb_adr_i = 11'h010; wb_dat_i = 16'hA55A; wb_sel_i = 2'b11;
      for (int i = 1; i <= 20; i++) begin
         disp_req_i = 1'b1;
         disp_adr_i = 11'(i);
         step();
         chk("cont stall", 80'(stall_cnt_o), 80'(i));
         chk("cont ovr",   80'(overrun_o), 80'((i >= 16) ? 1 : 0));
         chk("cont ack",   80'(wb_ack_o), 80'(0));
         chk("cont we",    80'(ram_we_o), 80'(0));
      end
      disp_req_i = 1'b0;
      step();
      chk("cont gnt we",  80'(ram_we_o), 80'(1));
      chk("cont gnt adr", 80'(ram_adr_o), 80'(11'h010));
      chk("cont gnt dat", 80'(ram_dat_o), 80'(16'hA55A));
      chk("cont gnt clr", 80'(stall_cnt_o), 80'(0));
      chk("cont gnt ack", 80'(wb_ack_o), 80'(0));
      step();
      chk("cont ack1", 80'(wb_ack_o), 80'(1));
      cpu_idle();
      step();
      chk("cont ack0", 80'(wb_ack_o), 80'(0));
      cpu_read("rd010", 11'h010, 16'hA55A);
      chk("ovr sticky", 80'(overrun_o), 80'(1));

      // Byte write onto the attribute byte, then an empty-select write.
      cpu_write("bw", 11'h020, 16'hFF00, 2'b10);
      cpu_read("rd020", 11'h020, 16'hFF34);
      cpu_write("sel0", 11'h020, 16'h0000, 2'b00);
      cpu_read("rd020b", 11'h020, 16'hFF34);

      // Register-space write alongside a display stream.
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_tga_i = 1'b1;
      wb_adr_i = 11'h000; wb_dat_i = 16'hFFFF; wb_sel_i = 2'b11;
      for (int i = 0; i < 6; i++) begin
         if (i == 1) cpu_idle();
         disp_req_i = (i < 4);
         disp_adr_i = 11'(i);
         step();
         chk("tga ack", 80'(wb_ack_o), 80'((i == 0) ? 1 : 0));
         chk("tga dat", 80'(wb_dat_o), 80'(0));
         chk("tga we",  80'(ram_we_o), 80'(0));
         chk("tga vld", 80'(disp_vld_o), 80'((i >= 1 && i <= 4) ? 1 : 0));
         if (i >= 1 && i <= 4)
            chk("tga disp", 80'(disp_dat_o), 80'(16'h0041 + 16'(i - 1)));
      end
      cpu_read("rd000", 11'h000, 16'h0041);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vdu_mem_arbiter.md
Name: vdu_mem_arbiter

Overview:
- Arbitrates the single-port 2048x16 VDU video RAM between the CPU Wishbone slave port and the display fetch pipeline.
- Display fetch has hard priority because it is real-time; the CPU is served in free cycles.
- Registers the RAM port, returns display data with a fixed latency, and acks CPU accesses.
- Reports CPU starvation through a stall counter and a sticky overrun flag.

Parameters:
- AW, 11, word-address width (video RAM depth = 2**AW).
- DW, 16, data width (char + attribute).
- STALL_LIMIT, 16, consecutive denied CPU cycles that set overrun_o.
- CW, 8, stall counter width; the counter saturates at 2**CW-1.

Ports:
- wb_clk_i  in  1  VDU clock (25 MHz); the only clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- wb_dat_i  in  DW  CPU write data.
- wb_dat_o  out  DW  CPU read data, valid while wb_ack_o=1.
- wb_adr_i  in  AW  CPU word address.
- wb_we_i  in  1  CPU write enable.
- wb_tga_i  in  1  1 = register space; not routed to RAM.
- wb_sel_i  in  2  byte selects ([1]=attribute, [0]=char).
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  single-cycle acknowledge.
- disp_req_i  in  1  display fetch request; one per cycle allowed.
- disp_adr_i  in  AW  display fetch address.
- disp_dat_o  out  DW  fetched word.
- disp_vld_o  out  1  disp_dat_o valid.
- ram_adr_o  out  AW  RAM address (registered).
- ram_we_o  out  1  RAM write enable (registered).
- ram_be_o  out  2  RAM byte enables (registered).
- ram_dat_o  out  DW  RAM write data (registered).
- ram_dat_i  in  DW  RAM read data; synchronous, valid one cycle after address.
- stall_cnt_o  out  CW  denied cycles of the current CPU access.
- overrun_o  out  1  sticky starvation flag.

Behaviour:
- Reset: asynchronous, active-low. While wb_rst_ni=0, every output is 0 and the FSM is IDLE. A pending CPU access is dropped without ack. A reset mid-operation aborts any in-flight display fetch, so no disp_vld_o is produced for it.
- CPU pending: cpu_pend = wb_cyc_i & wb_stb_i & (state==IDLE).
- Grant rule, evaluated at each edge:
  - If disp_req_i=1, display is granted.
  - Otherwise, if cpu_pend=1 and wb_tga_i=0, CPU is granted.
  - Otherwise no grant: ram_we_o=0; ram_adr_o holds its previous value.
- RAM port on a display grant (cycle k+1): ram_adr_o=disp_adr_i, ram_we_o=0, ram_be_o=2'b11.
- RAM port on a CPU grant (cycle k+1): ram_adr_o=wb_adr_i, ram_we_o=wb_we_i, ram_be_o=wb_sel_i, ram_dat_o=wb_dat_i.
- Display latency:
  - Request sampled at edge k; disp_vld_o=1 with disp_dat_o=ram_dat_i in cycle k+2.
  - Fully pipelined: N back-to-back requests give N back-to-back valids, in order.
- CPU FSM states: IDLE, BUSY, ACK, TACK.
  - IDLE -> BUSY on a CPU grant.
  - IDLE -> TACK when cpu_pend=1 and wb_tga_i=1. This path has no arbitration and no RAM use.
  - BUSY -> ACK unconditionally (the RAM op occupies cycle k+1).
  - ACK: wb_ack_o=1 for one cycle. For reads, wb_dat_o=ram_dat_i; for writes, wb_dat_o=0. Then -> IDLE.
  - TACK: wb_ack_o=1 for one cycle with wb_dat_o=0; writes are discarded. Then -> IDLE.
  - CPU access latency is 2 cycles after grant for both reads and writes.
  - IDLE does not re-sample stb in the same edge that leaves ACK/TACK, so a held stb is not double-granted.
  - A display grant during BUSY/ACK is legal: the RAM port was used by the CPU only in cycle k+1.
- Master abort: if wb_cyc_i drops in BUSY, the RAM op still completes and wb_ack_o is still asserted; the master ignores it.
- wb_sel_i=2'b00 write: ram_we_o=1 with ram_be_o=00 (no change to RAM); the access is still acked.
- Stall counter:
  - Increments (saturating at 2**CW-1) at each edge where cpu_pend=1, wb_tga_i=0 and display is granted.
  - Clears to 0 on a CPU grant, or when cpu_pend=0.
- Overrun: overrun_o sets when stall_cnt_o reaches STALL_LIMIT. It is cleared only by reset.

Decomposition:
- Package vdu_pkg holds the AW/DW defaults, the FSM state encoding (IDLE, BUSY, ACK, TACK) and the RAM byte-enable constants.
- One natural sub-module: vdu_stall_mon, containing the saturating counter and the sticky overrun flag.

Test Plan:
- Reset: drive wb_rst_ni=0 mid-access -> all outputs 0 immediately, no ack. Release -> wb_ack_o stays 0 until a new stb.
- CPU read, display idle: adr 11'h123, RAM holds 16'hBEEF -> wb_ack_o in the 2nd cycle after stb is sampled, wb_dat_o=16'hBEEF, ack width exactly 1.
- Display stream: disp_req_i high 4 cycles, addresses 0..3 holding 16'h0041..16'h0044 -> disp_vld_o high 4 consecutive cycles starting 2 cycles later, data in order.
- Contention: CPU write 16'hA55A to 11'h010 with disp_req_i held 20 cycles.
  - stall_cnt_o counts 1..20.
  - overrun_o rises at count 16.
  - CPU is granted the first cycle disp_req_i=0, then acked 2 cycles later.
  - RAM[11'h010]=16'hA55A.
- Byte write: sel=2'b10, data 16'hFF00 over RAM 16'h1234 -> ram_be_o=10, RAM reads back 16'hFF34.
- tga=1 read: ack 1 cycle after acceptance, wb_dat_o=0, ram_we_o never asserted, and display fetches running concurrently are unaffected.
